// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Round-robin arbiter for the common data bus of an out-of-order core. Each
// functional unit that holds a completed result raises its valid bit together
// with its reservation-station tag and result value. One requester per cycle
// is granted (combinationally). Its tag/value are then broadcast, registered,
// one cycle later. Tag 0 is reserved: a tag-0 requester is still granted, so
// it can retire its request, but it is never broadcast. Instead a sticky
// error flag is raised.
//
// Optional feature (macro CDB_STATS_EN): two saturating 16-bit statistics
// counters. One counts broadcasts. The other counts cycles in which a grant
// was made while two or more requesters were competing.
//
// Ports
//   clk               in   single clock, rising-edge active
//   reset             in   asynchronous, active-high reset
//   in_req_valid      in   [N_REQ]        requester i holds a completed result
//   in_req_tag        in   [N_REQ*TAG_W]  tag of requester i at [i*TAG_W +: TAG_W]
//   in_req_val        in   [N_REQ*DATA_W] value of requester i at [i*DATA_W +: DATA_W]
//   in_CDB_stall      in   consumers cannot accept a broadcast this cycle
//   out_grant         out  [N_REQ]  combinational one-hot grant
//   out_CDB_broadcast out  registered one-cycle broadcast strobe
//   out_CDB_tag       out  [TAG_W]  registered broadcast tag (held when idle)
//   out_CDB_val       out  [DATA_W] registered broadcast value (held when idle)
//   out_err_tag0      out  sticky: a tag-0 request has been granted
//   out_bcast_cnt     out  [16] saturating broadcast count     (CDB_STATS_EN)
//   out_conflict_cnt  out  [16] saturating contended-grant count (CDB_STATS_EN)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int N_REQ  = 4,   // number of requesters, 2..8
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        in_req_valid,
    input  logic [N_REQ*TAG_W-1:0]  in_req_tag,
    input  logic [N_REQ*DATA_W-1:0] in_req_val,
    input  logic                    in_CDB_stall,
    output logic [N_REQ-1:0]        out_grant,
    output logic                    out_CDB_broadcast,
    output logic [TAG_W-1:0]        out_CDB_tag,
    output logic [DATA_W-1:0]       out_CDB_val,
    output logic                    out_err_tag0
`ifdef CDB_STATS_EN
    ,
    output logic [15:0]             out_bcast_cnt,
    output logic [15:0]             out_conflict_cnt
`endif
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    // ------------------------------------------------------------------
    // Unpack the flat request buses into per-requester arrays.
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]  req_tag [N_REQ];
    logic [DATA_W-1:0] req_val [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_tag[g] = in_req_tag[g*TAG_W +: TAG_W];
        assign req_val[g] = in_req_val[g*DATA_W +: DATA_W];
    end

    // ------------------------------------------------------------------
    // Round-robin pointer: index of the requester searched first.
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] ptr;

    // (base + offset) mod N_REQ. Both operands are below N_REQ, so a single
    // conditional subtract is enough, even when N_REQ is not a power of two.
    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base,
                                                  input int               offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return PTR_W'(sum);
    endfunction

    // ------------------------------------------------------------------
    // Grant selection (combinational).
    // The search is suppressed entirely during stall or reset. Nothing is
    // remembered across a stall: the grant always reflects the inputs of
    // the current cycle only.
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] grant;
    logic             grant_any;
    logic [PTR_W-1:0] grant_idx;

    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        //       path through the search can leave one unassigned (no latch).
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        if (!reset && !in_CDB_stall) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!grant_any && in_req_valid[rr_index(ptr, k)]) begin
                    grant_any = 1'b1;
                    grant_idx = rr_index(ptr, k);
                end
            end
            if (grant_any) begin
                grant[grant_idx] = 1'b1;
            end
        end
    end

    assign out_grant = grant;

    // Tag 0 is reserved and must never appear on the bus.
    logic grant_tag0;
    logic grant_bcast;

    assign grant_tag0  = grant_any && (req_tag[grant_idx] == '0);
    assign grant_bcast = grant_any && !grant_tag0;

    // ------------------------------------------------------------------
    // Pointer update: advance past the winner, wrapping to 0.
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) only, so
    //       every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Broadcast register.
    // The strobe is recomputed every cycle, so it is a one-cycle pulse per
    // grant. Tag and value load only on a real broadcast and hold otherwise.
    // Asynchronous reset clears the strobe immediately, so a broadcast that
    // is pending when reset asserts is dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_CDB_broadcast <= 1'b0;
            out_CDB_tag       <= '0;
            out_CDB_val       <= '0;
        end else begin
            out_CDB_broadcast <= grant_bcast;
            if (grant_bcast) begin
                out_CDB_tag <= req_tag[grant_idx];
                out_CDB_val <= req_val[grant_idx];
            end
        end
    end

    // Sticky reserved-tag error; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_err_tag0 <= 1'b0;
        end else if (grant_tag0) begin
            out_err_tag0 <= 1'b1;
        end
    end

`ifdef CDB_STATS_EN
    // ------------------------------------------------------------------
    // Statistics. Both counters saturate at 16'hFFFF rather than wrap, so
    // a full counter reads as "at least this many".
    // The broadcast count steps on the same edge that raises the strobe.
    // ------------------------------------------------------------------
    logic contended;

    assign contended = grant_any && ($countones(in_req_valid) > 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_bcast_cnt    <= '0;
            out_conflict_cnt <= '0;
        end else begin
            if (grant_bcast && (out_bcast_cnt != 16'hFFFF)) begin
                out_bcast_cnt <= out_bcast_cnt + 16'd1;
            end
            if (contended && (out_conflict_cnt != 16'hFFFF)) begin
                out_conflict_cnt <= out_conflict_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
